// File: rtl/ppu_bg_fetch.sv
// ppu_bg_fetch: PPU background pipeline.
// Fetches nametable, attribute and pattern bytes one tile ahead of the beam.
// Also prefetches the first two tiles of the next line during the
// post-visible window, so pixel 0 of every line is already in the shifters.
// Four 16-bit shifters hold two tiles' worth of pattern and attribute bits,
// which lets fine X scroll pick any of the next eight pixels.
module ppu_bg_fetch #(
   parameter int          VIS_W      = 256,
   parameter int          VIS_H      = 240,
   parameter int          PRE_LINE   = 261,
   parameter int          PREFETCH_X = 320,
   parameter logic [13:0] NT_BASE    = 14'h2000,
   parameter int          CLIP_W     = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        pix_en,
   input  logic        en_bg,
   input  logic        en_left,
   input  logic [9:0]  nes_x_in,
   input  logic [9:0]  nes_y_in,
   input  logic [7:0]  scr_x_in,
   input  logic [7:0]  scr_y_in,
   input  logic [1:0]  nt_sel_in,
   input  logic        pt_sel_in,
   input  logic [7:0]  vram_data_in,
   output logic [13:0] vram_addr_out,
   output logic        vram_rd_out,
   output logic [3:0]  palette_out
);

   // Parameters narrowed to the dot/line counter width so that every
   // comparison below is between equal-width operands.
   localparam logic [9:0] VIS_W_L     = 10'(VIS_W);
   localparam logic [9:0] VIS_H_L     = 10'(VIS_H);
   localparam logic [9:0] PRE_LINE_L  = 10'(PRE_LINE);
   localparam logic [9:0] PF_FIRST_L  = 10'(PREFETCH_X);
   localparam logic [9:0] PF_LAST_L   = 10'(PREFETCH_X + 15);
   localparam logic [9:0] PF_YMAX_L   = 10'(VIS_H - 2);
   localparam logic [9:0] CLIP_W_L    = 10'(CLIP_W);

   // One nametable is 30 tile rows of 8 pixels; two stacked give 480 rows.
   localparam logic [9:0] NT_ROWS     = 10'd240;
   localparam logic [9:0] NT_ROWS2    = 10'd480;
   localparam logic [7:0] NT_ROWS_8   = 8'd240;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [13:0] addr_q,  addr_d;
   logic        rd_q,    rd_d;
   logic [3:0]  pal_q,   pal_d;
   logic [7:0]  tile_q,  tile_d;
   logic [1:0]  attr_q,  attr_d;
   logic [7:0]  lo_q,    lo_d;
   // Set at the first phase-0 dot seen inside a window; keeps a fetch
   // sequence that was cut short by reset from issuing half-formed reads.
   logic        sync_q,  sync_d;

   // ------------------------------------------------------------------
   // Window decode
   // ------------------------------------------------------------------
   logic       vis_x, vis_y, vis_win;
   logic       pf_x, pf_line, pf_win;
   logic       win, active;
   logic [2:0] phase;
   logic       clip_zone;

   assign vis_x     = (nes_x_in < VIS_W_L);
   assign vis_y     = (nes_y_in < VIS_H_L);
   assign vis_win   = vis_x && vis_y;
   assign pf_x      = (nes_x_in >= PF_FIRST_L) && (nes_x_in <= PF_LAST_L);
   assign pf_line   = (nes_y_in <= PF_YMAX_L) || (nes_y_in == PRE_LINE_L);
   assign pf_win    = pf_x && pf_line;
   assign win       = en_bg && (vis_win || pf_win);
   assign phase     = nes_x_in[2:0];
   assign active    = win && ((phase == 3'd0) || sync_q);
   assign clip_zone = (nes_x_in < CLIP_W_L) && !en_left;

   // ------------------------------------------------------------------
   // Scroll arithmetic
   // ------------------------------------------------------------------
   logic [5:0] tc;
   logic [5:0] hx;
   logic [4:0] cx;
   logic       nt_h;
   logic [9:0] ln;
   logic [7:0] scr_y_m;
   logic [9:0] row_sum;
   logic [9:0] row;
   logic       nt_v;
   logic [7:0] r8;
   logic [4:0] cy;
   logic [2:0] fy;

   // Tile column: the prefetch window fetches columns 0 and 1 of the next
   // line; the visible window runs two tiles ahead of the beam.
   assign tc = pf_win ? 6'((nes_x_in - PF_FIRST_L) >> 3)
                      : 6'(nes_x_in >> 3) + 6'd2;

   // 6-bit add wraps through both horizontal nametables.
   assign hx   = {nt_sel_in[0], scr_x_in[7:3]} + tc;
   assign cx   = hx[4:0];
   assign nt_h = hx[5];

   // Prefetch targets the following line; the pre-render line feeds line 0.
   assign ln = pf_win ? ((nes_y_in == PRE_LINE_L) ? 10'd0 : nes_y_in + 10'd1)
                      : nes_y_in;

   // Y scroll values past the last row alias back into the nametable.
   assign scr_y_m = (scr_y_in >= NT_ROWS_8) ? scr_y_in - NT_ROWS_8 : scr_y_in;

   // Sum stays below 960 for every legal line, so one wrap step suffices.
   assign row_sum = (nt_sel_in[1] ? NT_ROWS : 10'd0) + {2'b00, scr_y_m} + ln;
   assign row     = (row_sum >= NT_ROWS2) ? row_sum - NT_ROWS2 : row_sum;
   assign nt_v    = (row >= NT_ROWS);
   assign r8      = 8'(nt_v ? row - NT_ROWS : row);
   assign cy      = r8[7:3];
   assign fy      = r8[2:0];

   // ------------------------------------------------------------------
   // VRAM addresses
   // ------------------------------------------------------------------
   logic [13:0] nt_addr;
   logic [13:0] at_addr;
   logic [13:0] pt_addr;

   assign nt_addr = NT_BASE | {2'b00, nt_v, nt_h, cy, cx};
   assign at_addr = NT_BASE | {2'b00, nt_v, nt_h, 4'hF, cy[4:2], cx[4:2]};
   // Plane bit is phase[1]: phase 4 reads the low plane, phase 6 the high.
   assign pt_addr = {1'b0, pt_sel_in, tile_q, phase[1], fy};

   // Pick the 2-bit palette group for this tile's 16x16 quadrant.
   logic [1:0] attr_quad;

   always_comb begin
      attr_quad = vram_data_in[1:0];
      case ({cy[1], cx[1]})
         2'b00:   attr_quad = vram_data_in[1:0];
         2'b01:   attr_quad = vram_data_in[3:2];
         2'b10:   attr_quad = vram_data_in[5:4];
         default: attr_quad = vram_data_in[7:6];
      endcase
   end

   // ------------------------------------------------------------------
   // Shifters: 0 = pattern lo, 1 = pattern hi, 2 = attr lo, 3 = attr hi
   // ------------------------------------------------------------------
   logic       shift_en;
   logic       reload_en;
   logic [3:0] fine_sel;
   logic [3:0] pix_bit;
   logic [7:0] reload_byte [4];

   assign shift_en  = pix_en && win;
   assign reload_en = pix_en && active && (phase == 3'd7);
   // Bit 15 is the current pixel; fine X looks further right.
   assign fine_sel  = 4'd15 - {1'b0, scr_x_in[2:0]};

   // The high plane is still on the data bus at phase 7, so it loads direct.
   assign reload_byte[0] = lo_q;
   assign reload_byte[1] = vram_data_in;
   assign reload_byte[2] = {8{attr_q[0]}};
   assign reload_byte[3] = {8{attr_q[1]}};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_shift
         logic [15:0] sh_q, sh_d;

         // Shift one pixel per window dot; at phase 7 the new tile drops
         // into the low byte in the same step.
         always_comb begin
            sh_d = sh_q;
            if (shift_en) begin
               if (reload_en) begin
                  sh_d = {sh_q[14:7], reload_byte[gi]};
               end else begin
                  sh_d = {sh_q[14:0], 1'b0};
               end
            end
         end

         // Shifter state register.
         always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
               sh_q <= 16'd0;
            end else begin
               sh_q <= sh_d;
            end
         end

         assign pix_bit[gi] = sh_q[fine_sel];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Fetch sequencing and pixel output
   // ------------------------------------------------------------------

   // Next-state for the request, tile latches and output pixel.
   always_comb begin
      addr_d = addr_q;
      rd_d   = rd_q;
      pal_d  = pal_q;
      tile_d = tile_q;
      attr_d = attr_q;
      lo_d   = lo_q;
      sync_d = sync_q;
      if (pix_en) begin
         rd_d  = 1'b0;
         pal_d = 4'd0;
         if (win && (phase == 3'd0)) begin
            sync_d = 1'b1;
         end
         if (active) begin
            case (phase)
               3'd0: begin
                  rd_d   = 1'b1;
                  addr_d = nt_addr;
               end
               3'd1: tile_d = vram_data_in;
               3'd2: begin
                  rd_d   = 1'b1;
                  addr_d = at_addr;
               end
               3'd3: attr_d = attr_quad;
               3'd4: begin
                  rd_d   = 1'b1;
                  addr_d = pt_addr;
               end
               3'd5: lo_d = vram_data_in;
               3'd6: begin
                  rd_d   = 1'b1;
                  addr_d = pt_addr;
               end
               default: ;
            endcase
         end
         // Shifter taps are read before this dot's shift takes effect.
         if (vis_win && en_bg && !clip_zone) begin
            pal_d = pix_bit;
         end
      end
   end

   // Fetch and output state register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         addr_q <= 14'd0;
         rd_q   <= 1'b0;
         pal_q  <= 4'd0;
         tile_q <= 8'd0;
         attr_q <= 2'd0;
         lo_q   <= 8'd0;
         sync_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         rd_q   <= rd_d;
         pal_q  <= pal_d;
         tile_q <= tile_d;
         attr_q <= attr_d;
         lo_q   <= lo_d;
         sync_q <= sync_d;
      end
   end

   assign vram_addr_out = addr_q;
   assign vram_rd_out   = rd_q;
   assign palette_out   = pal_q;

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// tb_ppu_bg_fetch: directed checks of the background fetch pipeline.
// A small VRAM image answers combinationally from the registered address.
module tb_ppu_bg_fetch;

   logic        clk_in;
   logic        rst_in;
   logic        pix_en;
   logic        en_bg;
   logic        en_left;
   logic [9:0]  nes_x_in;
   logic [9:0]  nes_y_in;
   logic [7:0]  scr_x_in;
   logic [7:0]  scr_y_in;
   logic [1:0]  nt_sel_in;
   logic        pt_sel_in;
   logic [7:0]  vram_data_in;
   logic [13:0] vram_addr_out;
   logic        vram_rd_out;
   logic [3:0]  palette_out;

   logic [7:0]  vmem [0:16383];

   int n_total;
   int n_bad;

   ppu_bg_fetch dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .pix_en        (pix_en),
      .en_bg         (en_bg),
      .en_left       (en_left),
      .nes_x_in      (nes_x_in),
      .nes_y_in      (nes_y_in),
      .scr_x_in      (scr_x_in),
      .scr_y_in      (scr_y_in),
      .nt_sel_in     (nt_sel_in),
      .pt_sel_in     (pt_sel_in),
      .vram_data_in  (vram_data_in),
      .vram_addr_out (vram_addr_out),
      .vram_rd_out   (vram_rd_out),
      .palette_out   (palette_out)
   );

   assign vram_data_in = vmem[vram_addr_out];

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   // One PPU dot: pix_en high for one edge, then one idle edge so that
   // outputs are also seen holding between strobes.
   task automatic dot(input int x, input int y);
      @(negedge clk_in);
      nes_x_in = 10'(x);
      nes_y_in = 10'(y);
      pix_en   = 1'b1;
      @(negedge clk_in);
      pix_en   = 1'b0;
      @(posedge clk_in);
      #1;
   endtask

   task automatic prefetch();
      for (int x = 320; x < 336; x++) dot(x, 261);
   endtask

   initial begin
      int rd_cnt;
      int pal_cnt;
      logic [3:0] exp_pal;

      n_total = 0;
      n_bad   = 0;
      for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
      // Scroll 0: pre-line prefetch tiles 1 and 2, line 0 column 2 tile 5A.
      vmem[14'h2000] = 8'h01;  vmem[14'h2001] = 8'h02;  vmem[14'h2002] = 8'h5A;
      vmem[14'h23C0] = 8'h02;
      vmem[14'h0010] = 8'hF0;  vmem[14'h0018] = 8'h0F;
      vmem[14'h0020] = 8'hFF;  vmem[14'h0028] = 8'hFF;
      // Coarse X 31: tiles 3 (left table) and 4 (right table).
      vmem[14'h201F] = 8'h03;  vmem[14'h2400] = 8'h04;
      vmem[14'h23C7] = 8'h0C;  vmem[14'h27C0] = 8'h01;
      vmem[14'h0030] = 8'h10;  vmem[14'h0038] = 8'h00;
      vmem[14'h0040] = 8'h80;  vmem[14'h0048] = 8'h80;
      // Lower nametable row 0 column 2.
      vmem[14'h2802] = 8'h07;

      rst_in    = 1'b1;
      pix_en    = 1'b0;
      en_bg     = 1'b1;
      en_left   = 1'b1;
      nes_x_in  = 10'd0;
      nes_y_in  = 10'd0;
      scr_x_in  = 8'h00;
      scr_y_in  = 8'h00;
      nt_sel_in = 2'b00;
      pt_sel_in = 1'b0;

      repeat (3) @(posedge clk_in);
      #1;
      check_val("rst_addr", 16'(vram_addr_out), 16'h0000);
      check_val("rst_rd",   16'(vram_rd_out),   16'h0000);
      check_val("rst_pal",  16'(palette_out),   16'h0000);
      @(negedge clk_in);
      rst_in = 1'b0;

      // Pre-render prefetch of line 0, scroll 0.
      for (int x = 320; x < 336; x++) begin
         dot(x, 261);
         if (x == 320) begin
            check_val("pf_nt0_rd",   16'(vram_rd_out),   16'h0001);
            check_val("pf_nt0_addr", 16'(vram_addr_out), 16'h2000);
         end
         if (x == 322) check_val("pf_at0_addr", 16'(vram_addr_out), 16'h23C0);
         if (x == 324) check_val("pf_ptl_addr", 16'(vram_addr_out), 16'h0010);
         if (x == 326) check_val("pf_pth_addr", 16'(vram_addr_out), 16'h0018);
         if (x == 328) check_val("pf_nt1_addr", 16'(vram_addr_out), 16'h2001);
      end
      dot(336, 261);
      check_val("pf_end_rd",   16'(vram_rd_out),   16'h0000);
      check_val("pf_end_hold", 16'(vram_addr_out), 16'h0028);

      // Line 0 pixels and fetch addresses.
      for (int x = 0; x < 16; x++) begin
         dot(x, 0);
         exp_pal = (x < 4) ? 4'h9 : ((x < 8) ? 4'hA : 4'hB);
         check_val($sformatf("l0_pix%0d", x), 16'(palette_out), 16'(exp_pal));
         if (x == 0) check_val("l0_nt_addr", 16'(vram_addr_out), 16'h2002);
         if (x == 1) begin
            check_val("l0_ph1_rd",   16'(vram_rd_out),   16'h0000);
            check_val("l0_ph1_hold", 16'(vram_addr_out), 16'h2002);
         end
         if (x == 2) check_val("l0_at_addr",  16'(vram_addr_out), 16'h23C0);
         if (x == 4) check_val("l0_ptl_addr", 16'(vram_addr_out), 16'h05A0);
         if (x == 6) check_val("l0_pth_addr", 16'(vram_addr_out), 16'h05A8);
         if (x == 8) check_val("l0_nt3_addr", 16'(vram_addr_out), 16'h2003);
      end

      // Fine X 3, coarse X 31: two-tile window straddles the nametables.
      scr_x_in = 8'hFB;
      prefetch();
      for (int x = 0; x < 6; x++) begin
         dot(x, 0);
         if (x == 0) begin
            check_val("fx_nt_addr", 16'(vram_addr_out), 16'h2401);
            check_val("fx_pix0",    16'(palette_out),   16'h000D);
         end
         if (x == 1) check_val("fx_pix1", 16'(palette_out), 16'h000C);
         if (x == 5) check_val("fx_pix5", 16'(palette_out), 16'h0007);
      end
      scr_x_in = 8'h00;

      // Y scroll 239 on line 1 lands on row 0 of the lower nametable.
      scr_y_in = 8'hEF;
      for (int x = 0; x < 5; x++) begin
         dot(x, 1);
         if (x == 0) check_val("vy_nt_addr", 16'(vram_addr_out), 16'h2802);
         if (x == 2) check_val("vy_at_addr", 16'(vram_addr_out), 16'h2BC0);
         if (x == 4) check_val("vy_pt_addr", 16'(vram_addr_out), 16'h0070);
      end
      // Y scroll 245 aliases to 5: line 1 is row 6 of the top table.
      scr_y_in = 8'hF5;
      for (int x = 0; x < 5; x++) begin
         dot(x, 1);
         if (x == 0) check_val("vf5_nt_addr", 16'(vram_addr_out), 16'h2002);
         if (x == 4) check_val("vf5_pt_addr", 16'(vram_addr_out), 16'h05A6);
      end
      scr_y_in  = 8'h05;
      pt_sel_in = 1'b1;
      for (int x = 0; x < 5; x++) begin
         dot(x, 1);
         if (x == 4) check_val("v05_pt1_addr", 16'(vram_addr_out), 16'h15A6);
      end
      pt_sel_in = 1'b0;
      // Both nametable selects set, row wraps 480 back to 0.
      scr_y_in  = 8'hEF;
      nt_sel_in = 2'b11;
      dot(0, 1);
      check_val("vwrap_nt_addr", 16'(vram_addr_out), 16'h2402);
      scr_y_in  = 8'h00;
      nt_sel_in = 2'b00;

      // Left-column clip with opaque tiles.
      en_left = 1'b0;
      prefetch();
      for (int x = 0; x < 9; x++) begin
         dot(x, 0);
         exp_pal = (x < 8) ? 4'h0 : 4'hB;
         check_val($sformatf("clip_pix%0d", x), 16'(palette_out), 16'(exp_pal));
      end
      en_left = 1'b1;

      // Background disabled for a whole line.
      en_bg   = 1'b0;
      rd_cnt  = 0;
      pal_cnt = 0;
      for (int x = 0; x < 341; x++) begin
         dot(x, 5);
         if (vram_rd_out) rd_cnt++;
         if (palette_out != 4'h0) pal_cnt++;
      end
      check_val("nobg_rd_cnt",  16'(rd_cnt),  16'h0000);
      check_val("nobg_pal_cnt", 16'(pal_cnt), 16'h0000);
      en_bg = 1'b1;

      // Reset in the middle of line 0.
      prefetch();
      dot(100, 0);
      check_val("pre_rst_rd",   16'(vram_rd_out),   16'h0001);
      check_val("pre_rst_addr", 16'(vram_addr_out), 16'h0020);
      check_val("pre_rst_pal",  16'(palette_out),   16'h0009);
      #2;
      rst_in = 1'b1;
      #1;
      check_val("mid_rst_rd",   16'(vram_rd_out),   16'h0000);
      check_val("mid_rst_addr", 16'(vram_addr_out), 16'h0000);
      check_val("mid_rst_pal",  16'(palette_out),   16'h0000);
      @(negedge clk_in);
      rst_in = 1'b0;
      dot(101, 0);
      check_val("post_rst_pal", 16'(palette_out), 16'h0000);
      check_val("post_rst_rd",  16'(vram_rd_out), 16'h0000);
      dot(102, 0);
      check_val("post_rst_ph6_rd", 16'(vram_rd_out), 16'h0000);
      dot(103, 0);
      dot(104, 0);
      check_val("resume_rd",   16'(vram_rd_out),   16'h0001);
      check_val("resume_addr", 16'(vram_addr_out), 16'h200F);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
